hex_display_scanner: RTL and testbench
======================================

# hex_display_scanner

Multi-digit, time-multiplexed hexadecimal seven-segment display driver, the parametrised successor of the single-digit hex-to-segment decoder. It holds an N-digit hex value in a double-buffered register, scans one digit at a time onto shared segment lines with per-digit anode select, and adds per-digit decimal point, per-digit blanking, leading-zero suppression and tear-free frame-synchronous updates. It sits between the datapath (value producer) and the board's display pins.

## Interface
- NUM_DIGITS, 4: number of digits, at least 1
- CLK_DIV, 50000: clock cycles per digit slot, at least 2
- SEG_ACTIVE_LOW, 0: 1 inverts `seg` and `dp` at the output register
- AN_ACTIVE_LOW, 1: 1 inverts `an` at the output register

- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle strobe; captures `value`, `dp_in`, `digit_en`, `lz_en` into the shadow register
- value  in  4*NUM_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) is digit k, digit 0 least significant
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- digit_en  in  NUM_DIGITS  1 = digit displayed, 0 = digit forced blank
- lz_en  in  1  1 = leading-zero suppression on
- seg  out  7  segments {g,f,e,d,c,b,a}, logical 1 = lit before polarity
- dp  out  1  decimal point for the active digit
- an  out  NUM_DIGITS  one-hot digit select, logical 1 = on before polarity
- frame_tick  out  1  one-cycle pulse at each frame wrap
- pending  out  1  shadow holds data not yet shown

## Operation
- Segment map (hex → {g..a}): 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
- Prescaler `cnt` counts 0..CLK_DIV-1 and wraps. On wrap, digit index `idx` advances 0→1→…→NUM_DIGITS-1→0.
- Frame = NUM_DIGITS slots. The edge where `idx` wraps NUM_DIGITS-1→0 is the frame boundary.
- `load` high: shadow ← inputs, `pending` ← 1. Later loads before a boundary overwrite the shadow; only the last is shown.
- Frame boundary with `pending`=1: display register ← shadow, `pending` ← 0, unless `load` is high on the same edge. Then the display takes the old shadow, the shadow takes the new inputs, and `pending` stays 1.
- Digit k is blank (seg=0, dp=0, an bit k still driven) if `digit_en[k]`=0.
- Leading-zero suppression (display `lz_en`=1): digit k is blank if it and every higher-index enabled digit hold 0. Disabled digits are skipped in this search. Digit 0 is never suppressed. Its dp is still shown if set.
- Guard cycle: in the first cycle of every slot, `an`, `seg` and `dp` are all off (anti-ghosting). In the remaining CLK_DIV-1 cycles, `an` = one-hot(`idx`) and seg/dp come from the display register.
- `frame_tick` is high for the single cycle after the frame-boundary edge.

## Timing
- All outputs are registered and polarity is applied in the output register.
- Reset values (logical): `cnt`=0, `idx`=0, display and shadow = 0 (value 0, dp 0, digit_en 0, lz_en 0), `pending`=0, `frame_tick`=0, seg=0, dp=0, an=0. Physical pins take the inactive level per the polarity parameters.
- After reset release, the display stays blank until the first `load` plus a frame boundary, because digit_en is 0.
- Load-to-visible latency: up to NUM_DIGITS*CLK_DIV cycles, plus 1 for the output register.
- Slot layout: slot of digit k covers CLK_DIV consecutive cycles, 1 guard + CLK_DIV-1 driven. Frame period = NUM_DIGITS*CLK_DIV cycles exactly.
- `rst_n` low mid-frame: all state clears asynchronously and outputs go inactive immediately. The scan restarts at digit 0 with a full slot.
- NUM_DIGITS=1: `idx` is constant 0 and every slot wrap is a frame boundary.

## Test plan
- Reset: NUM_DIGITS=4, CLK_DIV=4, AN_ACTIVE_LOW=1; hold rst_n=0 → an=4'b1111, seg=0, pending=0. Release with no load → blank for 3 frames, frame_tick every 16 cycles.
- Scan: load value=16'h12AF, digit_en=4'hF, dp_in=0 → after next boundary, per slot, 1 guard cycle then 3 cycles of an=1110/seg=71, 1101/77, 1011/5B, 0111/06, repeating every 16 cycles.
- Leading zeros: load value=16'h0030, lz_en=1, dp_in=4'b0100 → digits 3 blank. Digit 2 shows 3F+dp, digit 1 shows 4F, digit 0 shows 3F. With lz_en=0, digit 3 shows 3F.
- Tear-free: load 16'h1111 mid-frame, then 16'h2222 two slots later → no 1s ever shown, 2s appear at the next boundary, pending 1→0 there.
- Collision: load asserted on the exact boundary edge while pending=1 → old shadow displayed, new data shown one frame later, pending stays 1 through the frame.
- Async reset mid-slot of digit 2 → outputs inactive the same cycle. After release, the scan restarts at digit 0 and the display register is cleared.

Source files
------------

// File: rtl/hex_display_scanner.sv
// Time-multiplexed N-digit hex seven-segment driver with shadow/display double
// buffering, per-digit dp/blanking, leading-zero suppression and guard cycles.
module hex_display_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_in_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic                    lz_en_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_tick_o,
    output logic                    pending_o
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] nib;
        logic [NUM_DIGITS-1:0]      dp;
        logic [NUM_DIGITS-1:0]      en;
        logic                       lz;
    } disp_t;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0: hex2seg = 7'h3F;  4'h1: hex2seg = 7'h06;
            4'h2: hex2seg = 7'h5B;  4'h3: hex2seg = 7'h4F;
            4'h4: hex2seg = 7'h66;  4'h5: hex2seg = 7'h6D;
            4'h6: hex2seg = 7'h7D;  4'h7: hex2seg = 7'h07;
            4'h8: hex2seg = 7'h7F;  4'h9: hex2seg = 7'h6F;
            4'hA: hex2seg = 7'h77;  4'hB: hex2seg = 7'h7C;
            4'hC: hex2seg = 7'h39;  4'hD: hex2seg = 7'h5E;
            4'hE: hex2seg = 7'h79;  default: hex2seg = 7'h71;
        endcase
    endfunction

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    disp_t                 shadow_q, shadow_d, disp_q, disp_d;
    logic                  pending_q, pending_d;
    logic                  tick_q;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  slot_wrap, frame_wrap;
    logic [NUM_DIGITS-1:0] sig, lz_blank;
    logic                  above;

    assign slot_wrap  = (cnt_q == CW'(CLK_DIV - 1));
    assign frame_wrap = slot_wrap && (idx_q == IW'(NUM_DIGITS - 1));

    // A lit dp marks a digit significant, so "0.3"-style values keep the zero.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_sig
        assign sig[k] = disp_q.en[k] && ((disp_q.nib[k] != 4'h0) || disp_q.dp[k]);
    end

    always_comb begin
        above    = 1'b0;
        lz_blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lz_blank[k] = disp_q.lz && (k != 0) && !above && !sig[k];
            above       = above | sig[k];
        end
    end

    always_comb begin
        cnt_d     = slot_wrap ? '0 : cnt_q + CW'(1);
        idx_d     = idx_q;
        if (frame_wrap)     idx_d = '0;
        else if (slot_wrap) idx_d = idx_q + IW'(1);

        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        if (frame_wrap && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end
        // A load on the boundary edge lands in the shadow after the old shadow moved out.
        if (load_i) begin
            shadow_d.nib = value_i;
            shadow_d.dp  = dp_in_i;
            shadow_d.en  = digit_en_i;
            shadow_d.lz  = lz_en_i;
            pending_d    = 1'b1;
        end
    end

    always_comb begin
        seg_d = '0;
        dp_d  = 1'b0;
        an_d  = '0;
        if (cnt_q != '0) begin
            an_d[idx_q] = 1'b1;
            if (disp_q.en[idx_q]) begin
                dp_d = disp_q.dp[idx_q];
                if (!lz_blank[idx_q]) seg_d = hex2seg(disp_q.nib[idx_q]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            seg_q     <= {7{SEG_ACTIVE_LOW}};
            dp_q      <= SEG_ACTIVE_LOW;
            an_q      <= {NUM_DIGITS{AN_ACTIVE_LOW}};
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            tick_q    <= frame_wrap;
            seg_q     <= seg_d ^ {7{SEG_ACTIVE_LOW}};
            dp_q      <= dp_d ^ SEG_ACTIVE_LOW;
            an_q      <= an_d ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
        end
    end

    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign an_o         = an_q;
    assign frame_tick_o = tick_q;
    assign pending_o    = pending_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench: 4 digits, 4 cycles per slot, active-low anodes, active-high segments.
module tb_hex_display_scanner;

    logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0, lz_en = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0, digit_en = '0;
    logic [6:0]  seg;
    logic        dp, frame_tick, pending;
    logic [3:0]  an;
    int          tests = 0, fails = 0, n;

    // physical anode pattern while digit d is driven
    localparam logic [3:0][3:0] AN_ON = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    hex_display_scanner #(.NUM_DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .load_i(load), .value_i(value), .dp_in_i(dp_in),
        .digit_en_i(digit_en), .lz_en_i(lz_en), .seg_o(seg), .dp_o(dp), .an_o(an),
        .frame_tick_o(frame_tick), .pending_o(pending));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!frame_tick && cnt < 40);
        if (!frame_tick) chk("tick_timeout", 12'(frame_tick), 12'd1);
    endtask

    task automatic load_disp(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en, input logic lz);
        value = v; dp_in = d; digit_en = en; lz_en = lz; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Starts at the negedge where frame_tick is seen, ends at the next such negedge.
    task automatic check_frame(input string tag, input logic [3:0][6:0] es, input logic [3:0] edp, input logic ep);
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            chk({tag, "_guard"}, {an, seg, dp}, {4'hF, 7'h00, 1'b0});
            if (d == 1) chk({tag, "_tick0"}, 12'(frame_tick), 12'd0);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk({tag, "_drv"}, {an, seg, dp}, {AN_ON[d], es[d], edp[d]});
                if (c == 0) chk({tag, "_pend"}, 12'(pending), 12'(ep));
            end
        end
        chk({tag, "_tick"}, 12'(frame_tick), 12'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_pins", {an, seg, dp}, {4'hF, 7'h00, 1'b0});
        chk("rst_pend", 12'(pending), 12'd0);
        chk("rst_tick", 12'(frame_tick), 12'd0);
        rst_n = 1'b1;
        wait_tick(n);
        chk("first_tick", 12'(n), 12'd16);
        repeat (3) check_frame("blank", '0, '0, 1'b0);

        load_disp(16'h12AF, 4'h0, 4'hF, 1'b0);
        wait_tick(n);
        chk("scan_pend_clr", 12'(pending), 12'd0);
        repeat (2) check_frame("scan", {7'h06, 7'h5B, 7'h77, 7'h71}, 4'h0, 1'b0);

        load_disp(16'h0030, 4'b0100, 4'hF, 1'b1);
        wait_tick(n);
        check_frame("lz1", {7'h00, 7'h3F, 7'h4F, 7'h3F}, 4'b0100, 1'b0);
        load_disp(16'h0030, 4'b0100, 4'hF, 1'b0);
        wait_tick(n);
        check_frame("lz0", {7'h3F, 7'h3F, 7'h4F, 7'h3F}, 4'b0100, 1'b0);

        // tear-free: two loads inside one frame, only the second reaches the display
        repeat (5) @(negedge clk);
        load_disp(16'h1111, 4'h0, 4'hF, 1'b0);
        chk("tear_pend1", 12'(pending), 12'd1);
        repeat (8) @(negedge clk);
        load_disp(16'h2222, 4'h0, 4'hF, 1'b0);
        chk("tear_pend2", 12'(pending), 12'd1);
        chk("tear_old", {an, seg, dp}, {4'b0111, 7'h3F, 1'b0});
        @(negedge clk);
        chk("tear_tick", 12'(frame_tick), 12'd1);
        chk("tear_pend0", 12'(pending), 12'd0);
        check_frame("tear", {7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'h0, 1'b0);

        // collision: second load captured on the boundary edge itself
        load_disp(16'h3333, 4'h0, 4'hF, 1'b0);
        repeat (14) @(negedge clk);
        load_disp(16'h4444, 4'h0, 4'hF, 1'b0);
        chk("coll_tick", 12'(frame_tick), 12'd1);
        chk("coll_pend", 12'(pending), 12'd1);
        check_frame("coll_old", {7'h4F, 7'h4F, 7'h4F, 7'h4F}, 4'h0, 1'b1);
        chk("coll_pend0", 12'(pending), 12'd0);
        check_frame("coll_new", {7'h66, 7'h66, 7'h66, 7'h66}, 4'h0, 1'b0);

        // async reset while digit 2 is driven
        repeat (9) @(negedge clk);
        load_disp(16'h5555, 4'h0, 4'hF, 1'b0);
        chk("mid_d2", {an, seg, dp}, {4'b1011, 7'h66, 1'b0});
        rst_n = 1'b0;
        #1;
        chk("arst_pins", {an, seg, dp}, {4'hF, 7'h00, 1'b0});
        chk("arst_pend", 12'(pending), 12'd0);
        chk("arst_tick", 12'(frame_tick), 12'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n);
        chk("rst2_tick", 12'(n), 12'd16);
        check_frame("post_rst", '0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
